// File: rtl/namco_io_chip.sv
// Namco 56xx/58xx-style custom I/O chip: 16x4 nibble register file plus a VBLANK-triggered
// command engine. Define NAMCO_IO_FREEPLAY_EN to report a fixed 99 credits and ignore coins.
module namco_io_chip #(
  parameter int unsigned COIN_PER_CRED = 1,
  parameter int unsigned CRED_MAX      = 99
) (
  input  logic        CLKCPUx2,
  input  logic        RESET,
  input  logic        IO_RESET,
  input  logic        VBLANK,
  input  logic        CS,
  input  logic        WE,
  input  logic [3:0]  ADRS,
  input  logic [3:0]  DI,
  output logic [3:0]  DO,
  input  logic [11:0] INP,
  input  logic [2:0]  BTN,
  input  logic [23:0] DSW,
  output logic        BUSY
);

  typedef enum logic [1:0] {StIdle, StCalc, StExec} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ram_q [16];
  logic [3:0]  ram_d [16];
  logic [3:0]  do_q, do_d;
  logic        vb_q;
  logic        busy_q, busy_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  mode_q, mode_d;
  logic [11:0] inp_q, inp_d;
  logic [2:0]  btn_q, btn_d;
  logic [23:0] dsw_q, dsw_d;
  logic [2:0]  hist_q, hist_d;
  logic [2:0]  edge_q, edge_d;
  logic [6:0]  cred_q, cred_d;
  logic [3:0]  presc_q, presc_d;

  logic        trig;
  logic [2:0]  new_edge;
  logic [5:0]  p1, p2;
  logic [3:0]  cred_tens, cred_ones;
  logic        exec_wr;
  logic [3:0]  exec_val;

  assign trig     = VBLANK & ~vb_q;
  assign new_edge = btn_q & ~hist_q;
  assign p1       = inp_q[5:0];
  assign p2       = inp_q[11:6];
  assign DO       = do_q;
  assign BUSY     = busy_q;

`ifdef NAMCO_IO_FREEPLAY_EN
  assign cred_tens = 4'd9;
  assign cred_ones = 4'd9;
`else
  logic [6:0] cred_tmp;
  assign cred_tens = 4'(cred_q / 7'd10);
  assign cred_ones = 4'(cred_q % 7'd10);
`endif

  // Result nibble for the current EXEC slot.
  always_comb begin
    exec_wr  = 1'b1;
    exec_val = 4'h0;
    case (mode_q)
      4'd1: begin
        case (idx_q)
          3'd0:    exec_val = cred_tens;
          3'd1:    exec_val = cred_ones;
          3'd2:    exec_val = p1[3:0];
          3'd3:    exec_val = {1'b0, edge_q[0], p1[5:4]};
          3'd4:    exec_val = p2[3:0];
          3'd5:    exec_val = {1'b0, edge_q[1], p2[5:4]};
          default: exec_val = 4'h0;
        endcase
      end
      4'd3: begin
        case (idx_q)
          3'd0:    exec_val = {1'b0, btn_q};
          3'd1:    exec_val = p1[3:0];
          3'd2:    exec_val = {2'b00, p1[5:4]};
          3'd3:    exec_val = p2[3:0];
          3'd4:    exec_val = {2'b00, p2[5:4]};
          default: exec_val = 4'h0;
        endcase
      end
      4'd4: begin
        if (idx_q < 3'd6) exec_val = dsw_q[{idx_q, 2'b00} +: 4];
      end
      4'd8: begin
        case (idx_q)
          3'd0:    exec_val = 4'd6;
          3'd1:    exec_val = 4'd9;
          default: exec_val = 4'h0;
        endcase
      end
      default: exec_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    inp_d   = inp_q;
    btn_d   = btn_q;
    dsw_d   = dsw_q;
    hist_d  = hist_q;
    edge_d  = edge_q;
    cred_d  = cred_q;
    presc_d = presc_q;
    ram_d   = ram_q;
    do_d    = ram_q[ADRS];
`ifndef NAMCO_IO_FREEPLAY_EN
    cred_tmp = cred_q;
`endif
    if (IO_RESET) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      cred_d  = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (trig) begin
            mode_d  = ram_q[8];
            inp_d   = INP;
            btn_d   = BTN;
            dsw_d   = DSW;
            state_d = StCalc;
          end
        end
        StCalc: begin
          edge_d  = new_edge;
          hist_d  = btn_q;
          busy_d  = 1'b1;
          idx_d   = 3'd0;
          state_d = StExec;
`ifndef NAMCO_IO_FREEPLAY_EN
          if (mode_q == 4'd1) begin
            if (new_edge[2]) begin
              if (32'(presc_q) + 32'd1 >= COIN_PER_CRED) begin
                presc_d = '0;
                if (32'(cred_tmp) < CRED_MAX) cred_tmp = cred_tmp + 7'd1;
              end else begin
                presc_d = presc_q + 4'd1;
              end
            end
            // Start1 takes priority; Start2 only considered when Start1 did not fire.
            if (new_edge[0] && cred_tmp >= 7'd1) cred_tmp = cred_tmp - 7'd1;
            else if (new_edge[1] && cred_tmp >= 7'd2) cred_tmp = cred_tmp - 7'd2;
            cred_d = cred_tmp;
          end
`endif
        end
        StExec: begin
          if (exec_wr) ram_d[{1'b0, idx_q}] = exec_val;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // CPU write overrides any engine write to the same nibble.
    if (CS && WE) ram_d[ADRS] = DI;
  end

  always_ff @(posedge CLKCPUx2) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) ram_q[i] <= 4'h0;
      state_q <= StIdle;
      do_q    <= 4'h0;
      vb_q    <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= 3'd0;
      mode_q  <= 4'h0;
      inp_q   <= '0;
      btn_q   <= '0;
      dsw_q   <= '0;
      hist_q  <= '0;
      edge_q  <= '0;
      cred_q  <= '0;
      presc_q <= '0;
    end else begin
      ram_q   <= ram_d;
      state_q <= state_d;
      do_q    <= do_d;
      vb_q    <= VBLANK;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      inp_q   <= inp_d;
      btn_q   <= btn_d;
      dsw_q   <= dsw_d;
      hist_q  <= hist_d;
      edge_q  <= edge_d;
      cred_q  <= cred_d;
      presc_q <= presc_d;
    end
  end

endmodule

// File: tb/tb_namco_io_chip.sv
// Scoreboard bench for namco_io_chip: two instances (1 and 2 coins per credit) on a shared bus,
// checked against a frame-level behavioural model.
module tb_namco_io_chip;

  logic        clk = 1'b0;
  logic        RESET, IO_RESET, VBLANK, CS, WE;
  logic [3:0]  ADRS, DI;
  logic [11:0] INP;
  logic [2:0]  BTN;
  logic [23:0] DSW;
  logic [3:0]  do0, do1;
  logic        busy0, busy1;

  always #5 clk = ~clk;

  namco_io_chip #(.COIN_PER_CRED(1), .CRED_MAX(99)) dut1 (
    .CLKCPUx2(clk), .RESET(RESET), .IO_RESET(IO_RESET), .VBLANK(VBLANK), .CS(CS), .WE(WE),
    .ADRS(ADRS), .DI(DI), .DO(do0), .INP(INP), .BTN(BTN), .DSW(DSW), .BUSY(busy0)
  );

  namco_io_chip #(.COIN_PER_CRED(2), .CRED_MAX(99)) dut2 (
    .CLKCPUx2(clk), .RESET(RESET), .IO_RESET(IO_RESET), .VBLANK(VBLANK), .CS(CS), .WE(WE),
    .ADRS(ADRS), .DI(DI), .DO(do1), .INP(INP), .BTN(BTN), .DSW(DSW), .BUSY(busy1)
  );

  typedef struct {
    string       name;
    bit          is_busy;
    logic [3:0]  e0;
    logic [3:0]  e1;
    int unsigned due;
  } item_t;

  item_t       sb[$];
  item_t       mon_it;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Model state, one slot per instance.
  logic [3:0] mem [2][16];
  int         cred [2];
  int         presc [2];
  int         cpc [2];
  logic [2:0] hist [2];
  bit         io_reset_on;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_it = sb.pop_front();
      if (mon_it.is_busy) begin
        check({mon_it.name, " dut1"}, {3'b000, busy0}, mon_it.e0);
        check({mon_it.name, " dut2"}, {3'b000, busy1}, mon_it.e1);
      end else begin
        check({mon_it.name, " dut1"}, do0, mon_it.e0);
        check({mon_it.name, " dut2"}, do1, mon_it.e1);
      end
    end
  end

  function automatic void push(input string nm, input bit b, input logic [3:0] e0,
                               input logic [3:0] e1);
    item_t it;
    it.name    = nm;
    it.is_busy = b;
    it.e0      = e0;
    it.e1      = e1;
    it.due     = cyc + 1;
    sb.push_back(it);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_credit(input int d, input logic [2:0] edg);
`ifndef NAMCO_IO_FREEPLAY_EN
    if (edg[2]) begin
      presc[d]++;
      if (presc[d] == cpc[d]) begin
        presc[d] = 0;
        if (cred[d] < 99) cred[d]++;
      end
    end
    if (edg[0] && cred[d] >= 1) cred[d] -= 1;
    else if (edg[1] && cred[d] >= 2) cred[d] -= 2;
`endif
  endfunction

  function automatic logic [3:0] model_result(input int d, input logic [3:0] mode, input int idx,
                                              input logic [11:0] inp, input logic [2:0] btn,
                                              input logic [2:0] edg, input logic [23:0] dsw);
    logic [5:0] a;
    logic [5:0] b;
    logic [3:0] v [8];
    a = inp[5:0];
    b = inp[11:6];
    for (int i = 0; i < 8; i++) v[i] = 4'h0;
    case (mode)
      4'd1: begin
`ifdef NAMCO_IO_FREEPLAY_EN
        v[0] = 4'd9;
        v[1] = 4'd9;
`else
        v[0] = 4'(cred[d] / 10);
        v[1] = 4'(cred[d] % 10);
`endif
        v[2] = a[3:0];
        v[3] = {1'b0, edg[0], a[5], a[4]};
        v[4] = b[3:0];
        v[5] = {1'b0, edg[1], b[5], b[4]};
      end
      4'd3: begin
        v[0] = {1'b0, btn};
        v[1] = a[3:0];
        v[2] = {2'b00, a[5:4]};
        v[3] = b[3:0];
        v[4] = {2'b00, b[5:4]};
      end
      4'd4: for (int i = 0; i < 6; i++) v[i] = 4'((dsw >> (4 * i)) & 24'hF);
      4'd8: begin
        v[0] = 4'd6;
        v[1] = 4'd9;
      end
      default: ;
    endcase
    return v[idx];
  endfunction

  task automatic cpu_write(input logic [3:0] a, input logic [3:0] v);
    ADRS = a;
    DI   = v;
    CS   = 1'b1;
    WE   = 1'b1;
    tick();
    CS = 1'b0;
    WE = 1'b0;
    for (int d = 0; d < 2; d++) mem[d][a] = v;
  endtask

  task automatic readall(input string tag);
    for (int a = 0; a < 16; a++) begin
      ADRS = 4'(a);
      CS   = 1'b1;
      WE   = 1'b0;
      push($sformatf("%s n%0d", tag, a), 1'b0, mem[0][a], mem[1][a]);
      tick();
    end
    CS = 1'b0;
  endtask

  // One VBLANK frame: c0 is the trigger cycle; optional CPU write at cycle wr_cyc and
  // IO_RESET assertion at cycle ior_cyc (negative = none).
  task automatic frame(input logic [11:0] inp, input logic [2:0] btn, input logic [23:0] dsw,
                       input int wr_cyc, input logic [3:0] wr_a, input logic [3:0] wr_d,
                       input int ior_cyc, input string tag);
    logic [3:0] r [2][8];
    logic [3:0] mode;
    logic [2:0] edg;
    bit         trig, calc_ok, wr_ok, exp_b;
    INP    = inp;
    BTN    = btn;
    DSW    = dsw;
    VBLANK = 1'b0;
    CS     = 1'b0;
    WE     = 1'b0;
    tick();
    trig    = !io_reset_on && (ior_cyc < 0 || ior_cyc > 0);
    calc_ok = trig && (ior_cyc < 0 || ior_cyc > 1);
    mode    = mem[0][8];
    wr_ok   = mode inside {4'd1, 4'd3, 4'd4, 4'd8};
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) r[d][i] = 4'h0;
      if (calc_ok) begin
        edg     = btn & ~hist[d];
        hist[d] = btn;
        if (mode == 4'd1) model_credit(d, edg);
        for (int i = 0; i < 8; i++) r[d][i] = model_result(d, mode, i, inp, btn, edg, dsw);
      end
    end
    VBLANK = 1'b1;
    for (int k = 0; k < 12; k++) begin
      CS = 1'b0;
      WE = 1'b0;
      if (k == ior_cyc) begin
        IO_RESET    = 1'b1;
        io_reset_on = 1'b1;
      end
      if (k == wr_cyc) begin
        ADRS = wr_a;
        DI   = wr_d;
        CS   = 1'b1;
        WE   = 1'b1;
      end
      if (k == 3) VBLANK = 1'b0;
      exp_b = trig && k >= 1 && k <= 8 && (ior_cyc < 0 || k < ior_cyc);
      push($sformatf("%s busy c%0d", tag, k), 1'b1, {3'b000, exp_b}, {3'b000, exp_b});
      tick();
      for (int d = 0; d < 2; d++) begin
        if (calc_ok && wr_ok && k >= 2 && k <= 9 && (ior_cyc < 0 || k < ior_cyc))
          mem[d][k-2] = r[d][k-2];
        if (k == wr_cyc) mem[d][wr_a] = wr_d;
      end
    end
    CS = 1'b0;
    WE = 1'b0;
    if (ior_cyc >= 0) begin
      for (int d = 0; d < 2; d++) begin
        cred[d]  = 0;
        presc[d] = 0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] m;
    RESET = 1'b1;
    IO_RESET = 1'b0;
    VBLANK = 1'b0;
    CS = 1'b0;
    WE = 1'b0;
    ADRS = 4'h0;
    DI = 4'h0;
    INP = '0;
    BTN = '0;
    DSW = '0;
    io_reset_on = 1'b0;
    cpc[0] = 1;
    cpc[1] = 2;
    for (int d = 0; d < 2; d++) begin
      cred[d]  = 0;
      presc[d] = 0;
      hist[d]  = 3'b000;
      for (int a = 0; a < 16; a++) mem[d][a] = 4'h0;
    end

    repeat (2) tick();
    RESET = 1'b0;
    push("reset busy", 1'b1, 4'h0, 4'h0);
    readall("reset");

    // One coin frame in credit mode.
    cpu_write(4'd8, 4'd1);
    frame(12'h000, 3'b100, 24'h0, -1, 4'h0, 4'h0, -1, "coin1");
    readall("coin1");

    // Second coin, then both starts together, then Start2 alone with one credit.
    frame(12'h000, 3'b000, 24'h0, -1, 4'h0, 4'h0, -1, "rel1");
    frame(12'h000, 3'b100, 24'h0, -1, 4'h0, 4'h0, -1, "coin2");
    frame(12'h000, 3'b000, 24'h0, -1, 4'h0, 4'h0, -1, "rel2");
    frame(12'h5A3, 3'b011, 24'h0, -1, 4'h0, 4'h0, -1, "start12");
    readall("start12");
    frame(12'h000, 3'b000, 24'h0, -1, 4'h0, 4'h0, -1, "rel3");
    frame(12'hC3C, 3'b010, 24'h0, -1, 4'h0, 4'h0, -1, "start2");
    readall("start2");

    // Saturation at 99 credits.
    for (int i = 0; i < 100; i++) begin
      frame(12'($urandom), 3'b100, 24'h0, -1, 4'h0, 4'h0, -1, "sat");
      frame(12'($urandom), 3'b000, 24'h0, -1, 4'h0, 4'h0, -1, "sat");
    end
    readall("sat");

    // DIP readout with a colliding CPU write on nibble 2.
    cpu_write(4'd8, 4'd4);
    frame(12'h000, 3'b000, 24'hA5C3F0, 4, 4'd2, 4'd7, -1, "dip");
    readall("dip");

    // Self-test interrupted by IO_RESET at EXEC idx 3.
    cpu_write(4'd3, 4'd0);
    cpu_write(4'd8, 4'd8);
    frame(12'h000, 3'b000, 24'h0, -1, 4'h0, 4'h0, 5, "iorst");
    readall("iorst");
    cpu_write(4'd8, 4'd1);
    frame(12'hFFF, 3'b000, 24'h0, -1, 4'h0, 4'h0, -1, "iohold");
    readall("iohold");
    IO_RESET = 1'b0;
    io_reset_on = 1'b0;
    tick();
    frame(12'h000, 3'b000, 24'h0, -1, 4'h0, 4'h0, -1, "zero");
    readall("zero");

    // Three coins: 3 credits at 1 coin/credit, 1 credit at 2 coins/credit.
    for (int i = 0; i < 3; i++) begin
      frame(12'h000, 3'b100, 24'h0, -1, 4'h0, 4'h0, -1, "coin3");
      frame(12'h000, 3'b000, 24'h0, -1, 4'h0, 4'h0, -1, "coin3");
    end
    readall("coin3");

    // Randomized frames across all modes.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: m = 4'd1;
        1: m = 4'd3;
        2: m = 4'd4;
        3: m = 4'd8;
        4: m = 4'd1;
        5: m = 4'd0;
        6: m = 4'd2;
        default: m = 4'($urandom_range(9, 15));
      endcase
      cpu_write(4'd8, m);
      frame(12'($urandom), 3'($urandom), 24'($urandom),
            ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(2, 11)),
            4'($urandom), 4'($urandom), -1, $sformatf("rnd%0d", i));
      readall($sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
